// File: rtl/kuuga_trace_reader.sv
`timescale 1ns/1ps
// kuuga_trace_reader
// Drains a trace repository one entry at a time. It issues a memory request for
// every entry with a nonzero address, keeps granted requests in an in-order
// tracker, and retires each trace index when its response returns.
//
// Build option: KUUGA_TRACE_READER_DEDUP_EN. When it is defined, an entry whose
// address matches an occupied tracker slot is skipped and no request is issued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              start/continue draining the repository
//   wr_idx              writer's next-write index (entries rd_idx..wr_idx-1 valid)
//   repo_rd_en/addr     repository read strobe and index
//   repo_rd_data        {instruction, mem_addr}, valid one cycle after repo_rd_en
//   mem_req/mem_addr    memory request and its address (held until granted)
//   mem_gnt/mem_rvalid  grant, and in-order response
//   retire_valid/index  one-cycle retire pulse and the retired trace index
//   busy                FSM not idle or requests outstanding
//   err                 sticky protocol error (stray rvalid or stray grant)
//
// state               | meaning
// IDLE                | wait for enable and a non-empty repository
// READ_ENTRY          | repository read strobe for rd_idx
// MAKE_REQUEST        | inspect entry: skip, stall on full tracker, or request
// WAIT_FOR_PROCESSING | mem_req held until granted, then slot allocated
module kuuga_trace_reader #(
  parameter int TRACE_ENTRIES    = 8192,
  parameter int DATA_ADDR_WIDTH  = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int TRACKER_DEPTH    = 4,
  localparam int IW = $clog2(TRACE_ENTRIES),
  localparam int TW = $clog2(TRACKER_DEPTH)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      enable,
  input  logic [IW-1:0]                             wr_idx,
  output logic                                      repo_rd_en,
  output logic [IW-1:0]                             repo_rd_addr,
  input  logic [INSTR_DATA_WIDTH+DATA_ADDR_WIDTH-1:0] repo_rd_data,
  output logic                                      mem_req,
  output logic [DATA_ADDR_WIDTH-1:0]                mem_addr,
  input  logic                                      mem_gnt,
  input  logic                                      mem_rvalid,
  output logic                                      retire_valid,
  output logic [IW-1:0]                             retire_index,
  output logic                                      busy,
  output logic                                      err
);

  typedef enum logic [1:0] {
    IDLE,
    READ_ENTRY,
    MAKE_REQUEST,
    WAIT_FOR_PROCESSING
  } state_t;

  state_t state;

  logic [IW-1:0]              rd_idx;
  logic [IW-1:0]              rd_idx_inc;
  logic                       entry_fresh;
  logic [DATA_ADDR_WIDTH-1:0] entry_addr_q;
  logic [DATA_ADDR_WIDTH-1:0] cur_addr;

  // Tracker: circular FIFO, allocated at tail on grant, freed at head on response.
  logic [TRACKER_DEPTH-1:0]   slot_occ;
  logic [IW-1:0]              slot_idx [TRACKER_DEPTH];
  logic [TW-1:0]              head;
  logic [TW-1:0]              tail;
  logic [TW:0]                count;

  logic trk_empty;
  logic trk_full;
  logic rsp_take;
  logic slot_free;
  logic gnt_take;
  logic dup_hit;

  // The instruction half of an entry is not needed to drive memory requests.
  logic unused_instr;
  assign unused_instr = ^repo_rd_data[INSTR_DATA_WIDTH+DATA_ADDR_WIDTH-1:DATA_ADDR_WIDTH];

  assign repo_rd_addr = rd_idx;
  assign rd_idx_inc   = (rd_idx == IW'(TRACE_ENTRIES - 1)) ? '0 : rd_idx + 1'b1;

  // Repository data is only valid in the first MAKE_REQUEST cycle; a stall on a
  // full tracker falls back to the copy captured then.
  assign cur_addr = entry_fresh ? repo_rd_data[DATA_ADDR_WIDTH-1:0] : entry_addr_q;

  assign trk_empty = (count == '0);
  assign trk_full  = (count == (TW+1)'(TRACKER_DEPTH));
  assign rsp_take  = mem_rvalid && !trk_empty;
  // A response arriving in the same cycle frees the head slot, so a full
  // tracker can still take a new grant.
  assign slot_free = !trk_full || rsp_take;
  assign gnt_take  = mem_gnt && mem_req && (state == WAIT_FOR_PROCESSING) && slot_free;

  assign busy = (state != IDLE) || (|slot_occ);

`ifdef KUUGA_TRACE_READER_DEDUP_EN
  logic [DATA_ADDR_WIDTH-1:0] slot_addr [TRACKER_DEPTH];

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < TRACKER_DEPTH; i++) begin
      if (slot_occ[i] && (slot_addr[i] == cur_addr)) dup_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TRACKER_DEPTH; i++) slot_addr[i] <= '0;
    end else if (gnt_take) begin
      slot_addr[tail] <= mem_addr;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_idx       <= '0;
      entry_fresh  <= 1'b0;
      entry_addr_q <= '0;
      repo_rd_en   <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      retire_valid <= 1'b0;
      retire_index <= '0;
      err          <= 1'b0;
      slot_occ     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      for (int i = 0; i < TRACKER_DEPTH; i++) slot_idx[i] <= '0;
    end else begin
      repo_rd_en   <= 1'b0;
      retire_valid <= 1'b0;
      entry_fresh  <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && (rd_idx != wr_idx)) begin
            state      <= READ_ENTRY;
            repo_rd_en <= 1'b1;
          end
        end
        READ_ENTRY: begin
          state       <= MAKE_REQUEST;
          entry_fresh <= 1'b1;
        end
        MAKE_REQUEST: begin
          entry_addr_q <= cur_addr;
          if ((cur_addr == '0) || dup_hit) begin
            rd_idx <= rd_idx_inc;
            state  <= IDLE;
          end else if (slot_free) begin
            mem_req  <= 1'b1;
            mem_addr <= cur_addr;
            state    <= WAIT_FOR_PROCESSING;
          end
        end
        WAIT_FOR_PROCESSING: begin
          if (gnt_take) begin
            mem_req <= 1'b0;
            rd_idx  <= rd_idx_inc;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Free before allocate: when both hit the same slot (full tracker), the
      // new allocation must win.
      if (rsp_take) begin
        slot_occ[head] <= 1'b0;
        head           <= head + 1'b1;
        retire_valid   <= 1'b1;
        retire_index   <= slot_idx[head];
      end
      if (gnt_take) begin
        slot_occ[tail] <= 1'b1;
        slot_idx[tail] <= rd_idx;
        tail           <= tail + 1'b1;
      end
      count <= count + {{TW{1'b0}}, gnt_take} - {{TW{1'b0}}, rsp_take};

      if ((mem_rvalid && trk_empty) || (mem_gnt && !mem_req)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kuuga_trace_reader.sv
`timescale 1ns/1ps
module tb_kuuga_trace_reader;

  localparam int IW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [IW-1:0] wr_idx;
  logic          repo_rd_en;
  logic [IW-1:0] repo_rd_addr;
  logic [63:0]   repo_rd_data;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic          retire_valid;
  logic [IW-1:0] retire_index;
  logic          busy;
  logic          err;

  kuuga_trace_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wr_idx       (wr_idx),
    .repo_rd_en   (repo_rd_en),
    .repo_rd_addr (repo_rd_addr),
    .repo_rd_data (repo_rd_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .retire_valid (retire_valid),
    .retire_index (retire_index),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  logic [63:0] repo_mem [8192];
  logic [63:0] exp_addr_q [$];
  logic [63:0] exp_ret_q [$];

  // responder controls
  bit auto_gnt = 1'b1;
  bit hold_rv = 1'b0;
  int release_n = 0;
  bit inject_rv = 1'b0;
  bit inject_gnt = 1'b0;
  int resp_lat = 2;
  int timers [$];

  initial begin
    for (int i = 0; i < 8192; i++) repo_mem[i] = '0;
    repo_rd_data = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  end

  // repository: data one cycle after the read strobe
  always @(posedge clk) if (repo_rd_en) repo_rd_data <= repo_mem[repo_rd_addr];

  // memory responder
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < timers.size(); i++) if (timers[i] > 0) timers[i]--;
    mem_rvalid = 1'b0;
    if (inject_rv) mem_rvalid = 1'b1;
    else if (timers.size() > 0 && timers[0] == 0 && (!hold_rv || release_n > 0)) begin
      mem_rvalid = 1'b1;
      void'(timers.pop_front());
      if (hold_rv) release_n--;
    end
    mem_gnt = inject_gnt || (auto_gnt && mem_req);
    if (auto_gnt && mem_req) timers.push_back(resp_lat);
  end

  // scoreboard monitor
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (rst_n) begin
      if (mem_req && !req_prev) begin
        req_cnt++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL req_addr: unexpected request addr=%0h", mem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          if ({32'h0, mem_addr} !== e) begin
            errors++;
            $display("FAIL req_addr: got %0h expected %0h", mem_addr, e);
          end
        end
      end
      if (retire_valid) begin
        checks++;
        if (exp_ret_q.size() == 0) begin
          errors++;
          $display("FAIL retire_index: unexpected retire index=%0d", retire_index);
        end else begin
          e = exp_ret_q.pop_front();
          if ({51'h0, retire_index} !== e) begin
            errors++;
            $display("FAIL retire_index: got %0d expected %0d", retire_index, e);
          end
        end
      end
    end
    req_prev = mem_req;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_drain(string name, int max_cyc);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_ret_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s: timeout with %0d requests and %0d retires outstanding",
               name, exp_addr_q.size(), exp_ret_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    wr_idx = '0;
    auto_gnt = 1'b1;
    hold_rv = 1'b0;
    release_n = 0;
    inject_rv = 1'b0;
    inject_gnt = 1'b0;
    timers.delete();
    exp_addr_q.delete();
    exp_ret_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b1;
    enable = 1'b0;
    wr_idx = '0;

    // reset state
    do_reset();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_repo_rd_en", repo_rd_en, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_index", retire_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_idx", repo_rd_addr, 0);

    // basic drain with a non-memory entry in the middle
    repo_mem[0] = {32'hA000_0000, 32'h0000_0100};
    repo_mem[1] = {32'hA000_0001, 32'h0000_0000};
    repo_mem[2] = {32'hA000_0002, 32'h0000_0200};
    exp_addr_q.push_back(64'h100);
    exp_addr_q.push_back(64'h200);
    exp_ret_q.push_back(0);
    exp_ret_q.push_back(2);
    base = req_cnt;
    wr_idx = 3;
    enable = 1'b1;
    wait_drain("basic_drain", 200);
    chk("basic_req_count", req_cnt - base, 2);
    chk("basic_rd_idx", repo_rd_addr, 3);
    chk("basic_err", err, 0);

    // full tracker stall, release, then same-cycle grant and response
    do_reset();
    for (int i = 0; i < 6; i++) begin
      repo_mem[i] = {32'hB000_0000, 32'h1000 + 32'(i * 4)};
      exp_addr_q.push_back(64'h1000 + 64'(i * 4));
      exp_ret_q.push_back(64'(i));
    end
    hold_rv = 1'b1;
    base = req_cnt;
    wr_idx = 6;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    chk("full_grant_count", req_cnt - base, 4);
    chk("full_stall_mem_req", mem_req, 0);
    chk("full_busy", busy, 1);
    release_n = 2;
    @(negedge clk);
    chk("fifth_req_next_cycle", mem_req, 1);
    @(negedge clk);
    @(negedge clk);
    chk("same_cycle_gnt_rvalid_err", err, 0);
    hold_rv = 1'b0;
    wait_drain("full_drain", 200);
    chk("full_rd_idx", repo_rd_addr, 6);
    chk("full_err", err, 0);

    // index wrap at the top of the repository
    do_reset();
    for (int i = 0; i < 6; i++) repo_mem[i] = '0;
    wr_idx = 13'd8191;
    enable = 1'b1;
    n = 0;
    while (!(repo_rd_addr == 13'd8191 && !busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_reach_8191", repo_rd_addr, 8191);
    repo_mem[8191] = {32'hC000_0000, 32'h0000_0040};
    repo_mem[0]    = {32'hC000_0001, 32'h0000_0044};
    exp_addr_q.push_back(64'h40);
    exp_addr_q.push_back(64'h44);
    exp_ret_q.push_back(8191);
    exp_ret_q.push_back(0);
    base = req_cnt;
    wr_idx = 13'd1;
    wait_drain("wrap_drain", 200);
    chk("wrap_req_count", req_cnt - base, 2);
    chk("wrap_rd_idx", repo_rd_addr, 1);

    // stray response sets a sticky error
    do_reset();
    repo_mem[0] = '0;
    inject_rv = 1'b1;
    @(negedge clk);
    inject_rv = 1'b0;
    chk("stray_rvalid_err", err, 1);
    repeat (5) @(negedge clk);
    chk("stray_rvalid_err_sticky", err, 1);

    // reset while waiting for a grant drops everything
    auto_gnt = 1'b0;
    repo_mem[0] = {32'hD000_0000, 32'h0000_0300};
    exp_addr_q.push_back(64'h300);
    wr_idx = 1;
    enable = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midwait_req_seen", mem_req, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_mem_req", mem_req, 0);
    chk("midwait_rst_err", err, 0);
    chk("midwait_rst_busy", busy, 0);
    enable = 1'b0;
    wr_idx = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midwait_no_pending_req", exp_addr_q.size(), 0);

    // grant with no request outstanding
    inject_gnt = 1'b1;
    @(negedge clk);
    inject_gnt = 1'b0;
    chk("stray_gnt_err", err, 1);

    // duplicate address handling
    do_reset();
    repo_mem[0] = {32'hE000_0000, 32'h0000_0080};
    repo_mem[1] = {32'hE000_0001, 32'h0000_0080};
    hold_rv = 1'b1;
    base = req_cnt;
`ifdef KUUGA_TRACE_READER_DEDUP_EN
    exp_addr_q.push_back(64'h80);
    exp_ret_q.push_back(0);
`else
    exp_addr_q.push_back(64'h80);
    exp_addr_q.push_back(64'h80);
    exp_ret_q.push_back(0);
    exp_ret_q.push_back(1);
`endif
    wr_idx = 2;
    enable = 1'b1;
    repeat (30) @(negedge clk);
`ifdef KUUGA_TRACE_READER_DEDUP_EN
    chk("dup_req_count", req_cnt - base, 1);
`else
    chk("dup_req_count", req_cnt - base, 2);
`endif
    chk("dup_rd_idx", repo_rd_addr, 2);
    hold_rv = 1'b0;
    wait_drain("dup_drain", 200);
    chk("dup_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
